// File: rtl/prog_seq.sv
// Program sequencer for the fetch stage: sequential, conditional, absolute and
// PC-relative flow, a hardware return-address stack, stall hold and sticky halt.
module prog_seq #(
    parameter int D  = 12,
    parameter int OW = 8,
    parameter int SD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       jcnd,
    input  logic [2:0]                 branch,
    input  logic [D-1:0]               target,
    input  logic [OW-1:0]              offset,
    output logic [D-1:0]               prog_ctr,
    output logic                       halted,
    output logic [$clog2(SD+1)-1:0]    stk_depth,
    output logic                       stk_ovf,
    output logic                       stk_unf
);

    localparam int PW = $clog2(SD + 1);
    localparam logic [PW-1:0] FULL = PW'(SD);

    typedef enum logic [2:0] {
        OP_SEQ  = 3'b000,
        OP_BT   = 3'b001,
        OP_BF   = 3'b010,
        OP_JMP  = 3'b011,
        OP_REL  = 3'b100,
        OP_CALL = 3'b101,
        OP_RET  = 3'b110,
        OP_HALT = 3'b111
    } op_t;

    // Storage is sized to the full pointer range so the pointer indexes it directly;
    // entries at or above SD are never written.
    logic [D-1:0]  stack [2**PW];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [D-1:0]  pc_next;
    logic [D-1:0]  pc_inc;
    logic [D-1:0]  off_ext;
    logic          halt_next;
    logic          ovf_next;
    logic          unf_next;
    logic          push;
    op_t           op;

    assign op        = op_t'(branch);
    assign pc_inc    = prog_ctr + D'(1);
    assign off_ext   = D'($signed(offset));
    assign stk_depth = ptr;

    // Next-state decode: halt and stall freeze everything, otherwise decode the op.
    always_comb begin
        pc_next   = prog_ctr;
        ptr_next  = ptr;
        halt_next = halted;
        ovf_next  = stk_ovf;
        unf_next  = stk_unf;
        push      = 1'b0;
        if (halted || stall) begin
            pc_next = prog_ctr;
        end else begin
            case (op)
                OP_SEQ: pc_next = pc_inc;
                OP_BT: begin
                    if (jcnd) pc_next = target;
                    else      pc_next = pc_inc;
                end
                OP_BF: begin
                    if (!jcnd) pc_next = target;
                    else       pc_next = pc_inc;
                end
                OP_JMP: pc_next = target;
                OP_REL: pc_next = prog_ctr + off_ext;
                OP_CALL: begin
                    pc_next = target;
                    if (ptr == FULL) begin
                        ovf_next = 1'b1;
                    end else begin
                        push     = 1'b1;
                        ptr_next = ptr + PW'(1);
                    end
                end
                OP_RET: begin
                    // An empty-stack return degrades to a sequential step.
                    if (ptr == PW'(0)) begin
                        unf_next = 1'b1;
                        pc_next  = pc_inc;
                    end else begin
                        pc_next  = stack[ptr - PW'(1)];
                        ptr_next = ptr - PW'(1);
                    end
                end
                OP_HALT: halt_next = 1'b1;
                default: pc_next = pc_inc;
            endcase
        end
    end

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_ctr <= D'(0);
            ptr      <= PW'(0);
            halted   <= 1'b0;
            stk_ovf  <= 1'b0;
            stk_unf  <= 1'b0;
        end else begin
            prog_ctr <= pc_next;
            ptr      <= ptr_next;
            halted   <= halt_next;
            stk_ovf  <= ovf_next;
            stk_unf  <= unf_next;
        end
    end

    // Return-address storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack[ptr] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_prog_seq.sv
// Self-checking bench for prog_seq: directed plan scenarios plus randomized ops,
// all compared against a queue-based behavioural model every cycle.
module tb_prog_seq;

    localparam int D  = 12;
    localparam int OW = 8;
    localparam int SD = 4;
    localparam int PW = $clog2(SD + 1);

    logic          clk;
    logic          reset;
    logic          stall;
    logic          jcnd;
    logic [2:0]    branch;
    logic [D-1:0]  target;
    logic [OW-1:0] offset;
    logic [D-1:0]  prog_ctr;
    logic          halted;
    logic [PW-1:0] stk_depth;
    logic          stk_ovf;
    logic          stk_unf;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_pc;
    int m_stk[$];
    bit m_halt;
    bit m_ovf;
    bit m_unf;

    prog_seq #(.D(D), .OW(OW), .SD(SD)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .jcnd     (jcnd),
        .branch   (branch),
        .target   (target),
        .offset   (offset),
        .prog_ctr (prog_ctr),
        .halted   (halted),
        .stk_depth(stk_depth),
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit stl, input int op, input bit jc,
                                input int tgt, input int off);
        int soff;
        if (rst) begin
            m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
            m_stk.delete();
        end else if (!m_halt && !stl) begin
            case (op)
                0: m_pc = (m_pc + 1) % 4096;
                1: m_pc = jc ? tgt : (m_pc + 1) % 4096;
                2: m_pc = !jc ? tgt : (m_pc + 1) % 4096;
                3: m_pc = tgt;
                4: begin
                    soff = (off >= 128) ? off - 256 : off;
                    m_pc = (m_pc + soff + 4096) % 4096;
                end
                5: begin
                    if (m_stk.size() == SD) m_ovf = 1;
                    else m_stk.push_back((m_pc + 1) % 4096);
                    m_pc = tgt;
                end
                6: begin
                    if (m_stk.size() == 0) begin
                        m_unf = 1;
                        m_pc = (m_pc + 1) % 4096;
                    end else begin
                        m_pc = m_stk.pop_back();
                    end
                end
                default: m_halt = 1;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("pc", 32'(prog_ctr), 32'(m_pc));
        check_eq("halted", 32'(halted), 32'(m_halt));
        check_eq("depth", 32'(stk_depth), 32'(m_stk.size()));
        check_eq("ovf", 32'(stk_ovf), 32'(m_ovf));
        check_eq("unf", 32'(stk_unf), 32'(m_unf));
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit rst, input bit stl, input int op, input bit jc,
                        input int tgt, input int off);
        reset  = rst;
        stall  = stl;
        branch = 3'(op);
        jcnd   = jc;
        target = D'(tgt);
        offset = OW'(off);
        @(posedge clk);
        model_update(rst, stl, op, jc, tgt, off);
        #1;
        compare_all();
    endtask

    initial begin
        int op;
        reset = 1'b1; stall = 1'b0; jcnd = 1'b0; branch = 3'b000;
        target = 12'h000; offset = 8'h00;
        m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
        @(negedge clk);

        // reset values
        step(1, 0, 3, 0, 12'h5A5, 0);
        check_eq("rst_pc", 32'(prog_ctr), 32'h0);
        check_eq("rst_flags", {29'd0, halted, stk_ovf, stk_unf}, 32'h0);

        // sequential and conditional branches
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        check_eq("seq5", 32'(prog_ctr), 32'h005);
        step(0, 0, 1, 0, 12'h100, 0);
        check_eq("bt_not_taken", 32'(prog_ctr), 32'h006);
        step(0, 0, 2, 0, 12'h100, 0);
        check_eq("bf_taken", 32'(prog_ctr), 32'h100);
        step(0, 0, 3, 0, 12'hFFF, 0);
        check_eq("jmp_fff", 32'(prog_ctr), 32'hFFF);
        step(0, 0, 0, 0, 0, 0);
        check_eq("seq_wrap", 32'(prog_ctr), 32'h000);

        // relative jumps with wrap in both directions
        step(0, 0, 3, 0, 12'h010, 0);
        step(0, 0, 4, 0, 0, 8'hF0);
        check_eq("rel_m16", 32'(prog_ctr), 32'h000);
        step(0, 0, 4, 0, 0, 8'hFF);
        check_eq("rel_m1_wrap", 32'(prog_ctr), 32'hFFF);
        step(0, 0, 4, 0, 0, 8'h7F);
        check_eq("rel_p127_wrap", 32'(prog_ctr), 32'h07E);

        // nested call / return
        step(0, 0, 3, 0, 12'h020, 0);
        step(0, 0, 5, 0, 12'h100, 0);
        step(0, 0, 5, 0, 12'h200, 0);
        check_eq("nest_depth", 32'(stk_depth), 32'd2);
        step(0, 0, 6, 0, 0, 0);
        check_eq("ret1", 32'(prog_ctr), 32'h101);
        step(0, 0, 6, 0, 0, 0);
        check_eq("ret2", 32'(prog_ctr), 32'h021);
        check_eq("nest_clean", {29'd0, stk_depth == 3'd0, stk_ovf, stk_unf}, 32'h4);

        // overflow and underflow
        step(0, 0, 3, 0, 12'h000, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 5, 0, 12'h300, 0);
        check_eq("ovf_depth", 32'(stk_depth), 32'd4);
        check_eq("ovf_flag", 32'(stk_ovf), 32'd1);
        check_eq("ovf_pc", 32'(prog_ctr), 32'h300);
        step(0, 0, 6, 0, 0, 0); check_eq("pop1", 32'(prog_ctr), 32'h301);
        step(0, 0, 6, 0, 0, 0); check_eq("pop2", 32'(prog_ctr), 32'h301);
        step(0, 0, 6, 0, 0, 0); check_eq("pop3", 32'(prog_ctr), 32'h301);
        step(0, 0, 6, 0, 0, 0); check_eq("pop4", 32'(prog_ctr), 32'h001);
        step(0, 0, 6, 0, 0, 0);
        check_eq("unf_flag", 32'(stk_unf), 32'd1);
        check_eq("unf_pc", 32'(prog_ctr), 32'h002);

        // call immediately followed by return
        step(0, 0, 5, 0, 12'h4AB, 0);
        step(0, 0, 6, 0, 0, 0);
        check_eq("call_ret", 32'(prog_ctr), 32'h003);

        // stall hold
        for (int i = 0; i < 3; i++) step(0, 1, 3, 0, 12'h055, 0);
        check_eq("stall_pc", 32'(prog_ctr), 32'h003);
        step(0, 0, 3, 0, 12'h055, 0);
        check_eq("stall_release", 32'(prog_ctr), 32'h055);

        // halt, frozen under random traffic, then reset
        step(0, 0, 3, 0, 12'h040, 0);
        step(0, 0, 7, 0, 0, 0);
        check_eq("halt_set", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++)
            step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)));
        check_eq("halt_pc", 32'(prog_ctr), 32'h040);
        step(1, 1, 5, 0, 12'h777, 0);
        check_eq("halt_rst_pc", 32'(prog_ctr), 32'h0);
        check_eq("halt_rst_flags", {29'd0, halted, stk_ovf, stk_unf}, 32'h0);
        step(0, 0, 0, 0, 0, 0);
        check_eq("post_rst1", 32'(prog_ctr), 32'h001);
        step(0, 0, 0, 0, 0, 0);
        check_eq("post_rst2", 32'(prog_ctr), 32'h002);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            op = int'($urandom_range(0, 7));
            if (op == 7 && $urandom_range(0, 7) != 0) op = 0;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), op,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                 int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_seq.md
# prog_seq

Next-generation program sequencer for the core's fetch stage, replacing the fixed-function program counter. It keeps the existing absolute and conditional jump modes, and adds several new behaviours: signed PC-relative jumps, a parametrised hardware return-address stack for call/return, a stall hold and a sticky halt. It sits between decode (which supplies `branch`, `target`, `offset`) and instruction memory (which consumes `prog_ctr`).

## Interface
- `D`, 12: program counter / address width in bits.
- `OW`, 8: width of the signed relative offset; must satisfy 2 ≤ OW ≤ D.
- `SD`, 4: return-address stack depth in entries; must be ≥ 1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all state this cycle (op ignored).
- `jcnd`  in  1  branch condition from ALU flags.
- `branch`  in  3  control op (encoding below).
- `target`  in  D  absolute jump/call destination.
- `offset`  in  OW  signed two's-complement relative displacement.
- `prog_ctr`  out  D  current program counter (registered).
- `halted`  out  1  sticky halt status.
- `stk_depth`  out  $clog2(SD+1)  number of valid stack entries.
- `stk_ovf`  out  1  sticky: a call found the stack full.
- `stk_unf`  out  1  sticky: a return found the stack empty.

## Operation
- `branch` encoding:
  - 000 SEQ: pc+1.
  - 001 BT: target if `jcnd`, else pc+1.
  - 010 BF: target if `!jcnd`, else pc+1.
  - 011 JMP: target.
  - 100 REL: pc + sign_extend(offset).
  - 101 CALL: push pc+1, then go to target.
  - 110 RET: pop, go to popped value.
  - 111 HALT: set `halted`, pc unchanged.
- Priority per edge: reset > halted > stall > op decode.
- Arithmetic:
  - All pc math is modulo 2^D; pc+1 from all-ones wraps to 0.
  - REL wraps both directions.
  - `offset` is sign-extended to D bits before the add.
- Stack: LIFO of D-bit entries with a pointer 0..SD. `stk_depth` equals the pointer.
- CALL with `stk_depth`==SD (full):
  - The push is dropped; stack contents and depth are unchanged.
  - `stk_ovf` is set.
  - The jump to `target` still occurs.
- RET with `stk_depth`==0 (empty):
  - `stk_unf` is set.
  - pc <= pc+1 (the return is treated as a no-op).
  - Depth stays 0.
- Once `halted`=1:
  - pc, stack and flags are frozen regardless of `stall`/`branch`.
  - Only `reset` clears the halt.
- `stall`=1: pc, stack, depth and flags all hold; `jcnd`/`target`/`offset` are don't-care.
- `stk_ovf`/`stk_unf` are sticky until reset and have no effect on sequencing beyond the rules above.

## Timing
- Reset values:
  - `prog_ctr`=0, `halted`=0, `stk_depth`=0, `stk_ovf`=0, `stk_unf`=0.
  - Stack storage content is don't-care after reset.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the op presented in cycle N is reflected in `prog_ctr` and `stk_depth` after the rising edge ending cycle N. Taken branches have one-cycle latency, identical to SEQ.
- CALL followed immediately by RET in the next cycle returns to the pushed pc+1 (back-to-back push/pop is legal).
- Reset asserted mid-sequence (during a stall, while halted, or with the stack partly full) takes effect at the next edge and fully reinitialises state. The op presented in that same cycle is ignored.
- Deassertion of reset: the first op is decoded in the first cycle with `reset`=0, starting from pc=0.

## Test plan
- Reset then 5× SEQ, followed by BT with `jcnd`=0, `target`=0x100 → `prog_ctr` 0,1,2,3,4,5,6. Then BF with `jcnd`=0, `target`=0x100 → 0x100. Then JMP `target`=0xFFF, then SEQ → 0xFFF, then 0x000 (wrap).
- With pc=0x010: REL `offset`=8'hF0 (-16) → 0x000. Then REL `offset`=8'hFF → 0xFFF. Then REL `offset`=8'h7F → 0x07E.
- Nested calls with SD=4:
  - From pc=0x020, CALL 0x100; at 0x100, CALL 0x200 → `stk_depth`=2.
  - RET → 0x101; RET → 0x021; `stk_depth`=0, no flags set.
- Overflow/underflow:
  - 5 consecutive CALLs (target 0x300) starting at pc=0x000 → `stk_depth` saturates at 4, `stk_ovf`=1 on the 5th, pc=0x300.
  - 4 RETs pop 0x301,0x301,0x301,0x001.
  - A 5th RET → `stk_unf`=1, pc=0x002.
- Stall: assert `stall` for 3 cycles while presenting JMP 0x055 → pc and `stk_depth` unchanged. On release, JMP takes effect → pc=0x055.
- Halt and reset: HALT at pc=0x040 → `halted`=1 and pc held at 0x040 for 10 cycles under random ops and `stall`. Then `reset`=1 for one cycle → all outputs reset values, pc=0 and counting normally afterwards.
